// File: rtl/spi_slave_control.sv
// spi_slave_control: SPI target endpoint. SCK, SS and MOSI are oversampled in the clk_cpu
// domain. Each selected word shifts a CPU-supplied TX word out on MISO and assembles the
// received bits into SPI_RX_DATA.
//
// Ports:
//   clk_cpu, rst        system clock, synchronous active-high reset
//   SPI_SLV_CTRL[6:0]   {ON, CPOL, CPHA, BIT_ORDER, DATA_LEN[1:0], I_MSK}
//   SPI_TX_DATA         right-justified word to send, sampled at word start
//   SPI_RX_DATA         last complete received word, right-justified, zero-extended
//   rx_valid / rx_ack   word-available flag and its CPU acknowledge
//   overrun             sticky: a word completed while rx_valid was still set
//   SCK, SS, MOSI       asynchronous bus pins from the master
//   MISO, MISO_OE       serial data out and pad output enable
//   interrpt            level interrupt, rx_valid gated by I_MSK
module spi_slave_control #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk_cpu,
    input  logic                  rst,
    input  logic [6:0]            SPI_SLV_CTRL,
    input  logic [DATA_WIDTH-1:0] SPI_TX_DATA,
    output logic [DATA_WIDTH-1:0] SPI_RX_DATA,
    output logic                  rx_valid,
    input  logic                  rx_ack,
    output logic                  overrun,
    input  logic                  SCK,
    input  logic                  SS,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic                  MISO_OE,
    output logic                  interrpt
);
    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StActive, StDone} state_t;

    logic       ctrl_on, ctrl_cpol, ctrl_cpha, ctrl_lsb, ctrl_imsk;
    logic [1:0] ctrl_len;

    assign ctrl_on   = SPI_SLV_CTRL[6];
    assign ctrl_cpol = SPI_SLV_CTRL[5];
    assign ctrl_cpha = SPI_SLV_CTRL[4];
    assign ctrl_lsb  = SPI_SLV_CTRL[3];
    assign ctrl_len  = SPI_SLV_CTRL[2:1];
    assign ctrl_imsk = SPI_SLV_CTRL[0];

    // Pin synchronizers plus one delayed copy for edge detection.
    logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
    logic                   sck_dly, ss_dly;
    logic                   sck_s, ss_s, mosi_s;

    always_ff @(posedge clk_cpu) begin
        if (rst) begin
            sck_sync  <= {SYNC_STAGES{ctrl_cpol}};
            ss_sync   <= '1;
            mosi_sync <= '0;
            sck_dly   <= ctrl_cpol;
            ss_dly    <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sck_dly   <= sck_sync[SYNC_STAGES-1];
            ss_dly    <= ss_sync[SYNC_STAGES-1];
        end
    end

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Transaction state
    state_t                state, state_next;
    logic                  xfer_cpol, xfer_cpha, xfer_lsb;
    logic                  xfer_cpol_next, xfer_cpha_next, xfer_lsb_next;
    logic [1:0]            xfer_len, xfer_len_next;
    logic [DATA_WIDTH-1:0] tx_shift, tx_next, rx_shift, rx_next, tx_load;
    logic [DATA_WIDTH-1:0] rx_data_next;
    logic [CW-1:0]         bit_cnt, cnt_next, cnt_inc, n_bits;
    logic                  rx_valid_next, overrun_next, miso_next, oe, oe_next;
    logic                  sck_rise, sck_fall, ss_rise, ss_fall;
    logic                  lead_edge, trail_edge, sample_edge, shift_edge;
    logic [4:0]            pad;

    assign sck_rise    = sck_s & ~sck_dly;
    assign sck_fall    = ~sck_s & sck_dly;
    assign ss_rise     = ss_s & ~ss_dly;
    assign ss_fall     = ~ss_s & ss_dly;
    assign lead_edge   = xfer_cpol ? sck_fall : sck_rise;
    assign trail_edge  = xfer_cpol ? sck_rise : sck_fall;
    assign sample_edge = xfer_cpha ? trail_edge : lead_edge;
    assign shift_edge  = xfer_cpha ? lead_edge : trail_edge;

    // Unused high bits of a short word: 8*(3-len), i.e. {~len, 3'b000}.
    assign pad     = {~xfer_len, 3'b000};
    assign n_bits  = CW'({xfer_len, 3'b000}) + CW'(8);
    assign cnt_inc = bit_cnt + CW'(1);

    // MSB-first words are left-justified so the next bit is always the top bit;
    // LSB-first words stay right-justified with bits above N cleared.
    function automatic logic [DATA_WIDTH-1:0] justify(input logic [DATA_WIDTH-1:0] word,
                                                      input logic lsb_first,
                                                      input logic [1:0] len_code);
        logic [4:0]            sh;
        logic [DATA_WIDTH-1:0] w;
        sh = {~len_code, 3'b000};
        w  = word << sh;
        if (lsb_first) w = w >> sh;
        return w;
    endfunction

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb_first);
        return lsb_first ? w[0] : w[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w,
                                                      input logic lsb_first);
        return lsb_first ? (w >> 1) : (w << 1);
    endfunction

    always_comb begin
        state_next     = state;
        xfer_cpol_next = xfer_cpol;
        xfer_cpha_next = xfer_cpha;
        xfer_lsb_next  = xfer_lsb;
        xfer_len_next  = xfer_len;
        tx_next        = tx_shift;
        rx_next        = rx_shift;
        cnt_next       = bit_cnt;
        rx_data_next   = SPI_RX_DATA;
        rx_valid_next  = rx_valid & ~rx_ack;
        overrun_next   = overrun & ~rx_ack;
        miso_next      = MISO;
        oe_next        = oe;
        tx_load        = '0;

        case (state)
            StIdle: begin
                miso_next = 1'b0;
                oe_next   = 1'b0;
                if (ctrl_on && ss_fall) begin
                    xfer_cpol_next = ctrl_cpol;
                    xfer_cpha_next = ctrl_cpha;
                    xfer_lsb_next  = ctrl_lsb;
                    xfer_len_next  = ctrl_len;
                    tx_load        = justify(SPI_TX_DATA, ctrl_lsb, ctrl_len);
                    tx_next        = tx_load;
                    rx_next        = '0;
                    cnt_next       = '0;
                    oe_next        = 1'b1;
                    state_next     = StActive;
                    if (!ctrl_cpha) begin
                        miso_next = first_bit(tx_load, ctrl_lsb);
                        tx_next   = advance(tx_load, ctrl_lsb);
                    end
                end
            end
            StActive: begin
                if (ss_rise) begin
                    state_next = StIdle;
                    oe_next    = 1'b0;
                    miso_next  = 1'b0;
                end else begin
                    if (sample_edge) begin
                        rx_next  = xfer_lsb ? {mosi_s, rx_shift[DATA_WIDTH-1:1]}
                                            : {rx_shift[DATA_WIDTH-2:0], mosi_s};
                        cnt_next = cnt_inc;
                        if (cnt_inc == n_bits) state_next = StDone;
                    end
                    // With CPHA=0 the first bit is already on MISO; a shift edge before any
                    // sample is the tail of the previous word and must not advance.
                    if (shift_edge && (xfer_cpha || bit_cnt != '0)) begin
                        miso_next = first_bit(tx_shift, xfer_lsb);
                        tx_next   = advance(tx_shift, xfer_lsb);
                    end
                end
            end
            StDone: begin
                rx_data_next  = xfer_lsb ? (rx_shift >> pad) : rx_shift;
                rx_valid_next = 1'b1;
                overrun_next  = (overrun | rx_valid) & ~rx_ack;
                if (!ss_s) begin
                    tx_load    = justify(SPI_TX_DATA, xfer_lsb, xfer_len);
                    tx_next    = tx_load;
                    rx_next    = '0;
                    cnt_next   = '0;
                    state_next = StActive;
                    if (!xfer_cpha) begin
                        miso_next = first_bit(tx_load, xfer_lsb);
                        tx_next   = advance(tx_load, xfer_lsb);
                    end
                end else begin
                    state_next = StIdle;
                    oe_next    = 1'b0;
                    miso_next  = 1'b0;
                end
            end
            default: state_next = StIdle;
        endcase

        if (!ctrl_on) begin
            state_next = StIdle;
            oe_next    = 1'b0;
            miso_next  = 1'b0;
        end
    end

    always_ff @(posedge clk_cpu) begin
        if (rst) begin
            state       <= StIdle;
            xfer_cpol   <= 1'b0;
            xfer_cpha   <= 1'b0;
            xfer_lsb    <= 1'b0;
            xfer_len    <= 2'b00;
            tx_shift    <= '0;
            rx_shift    <= '0;
            bit_cnt     <= '0;
            SPI_RX_DATA <= '0;
            rx_valid    <= 1'b0;
            overrun     <= 1'b0;
            MISO        <= 1'b0;
            oe          <= 1'b0;
        end else begin
            state       <= state_next;
            xfer_cpol   <= xfer_cpol_next;
            xfer_cpha   <= xfer_cpha_next;
            xfer_lsb    <= xfer_lsb_next;
            xfer_len    <= xfer_len_next;
            tx_shift    <= tx_next;
            rx_shift    <= rx_next;
            bit_cnt     <= cnt_next;
            SPI_RX_DATA <= rx_data_next;
            rx_valid    <= rx_valid_next;
            overrun     <= overrun_next;
            MISO        <= miso_next;
            oe          <= oe_next;
        end
    end

    // Drop the enable as soon as the deselect is seen, not a cycle later.
    assign MISO_OE  = oe & ctrl_on & ~ss_rise;
    assign interrpt = rx_valid & ctrl_imsk;

endmodule
